// File: rtl/regfile_bypass_sb.sv
// Multi-read, dual-write register file with busy scoreboard, optional write-to-read forwarding and a sequenced clear engine.
// Latency: reads are combinational (zero cycles); writes, issue marks and clear steps take effect on the next posedge clk.
// Backpressure: none. While clearing, clr_busy=1 and writes, issues and clr_req are dropped rather than held or queued.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rd_addr/rd_data     NRD packed read ports (port k: [k*AW +: AW] / [k*XLEN +: XLEN])
//   rd_busy             per-port scoreboard bit for the addressed register
//   wb0_*/wb1_*         writeback ports; wb1 wins when both target the same register
//   iss_en/iss_addr     marks the issuing instruction's destination busy
//   clr_req/clr_busy    start / activity flag of the register-by-register clear
//   debug_addr/_data    raw array read with no forwarding
// Build option: define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_bypass_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wb0_en,
  input  logic [AW-1:0]       wb0_addr,
  input  logic [XLEN-1:0]     wb0_data,
  input  logic                wb1_en,
  input  logic [AW-1:0]       wb1_addr,
  input  logic [XLEN-1:0]     wb1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  input  logic [AW-1:0]       debug_addr,
  output logic [XLEN-1:0]     debug_data
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // Register 0 is skipped by the clear engine when it is hard-wired to zero.
  localparam logic [AW-1:0] CLR_START = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] CLR_LAST  = AW'(NREGS - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic idle;
  logic wb0_ok, wb1_ok, iss_ok;

  // Qualified requests: only honoured in IDLE, and never for x0 when it is hard-wired.
  assign idle   = (state_q == IDLE);
  assign wb0_ok = idle && wb0_en && !((ZERO_REG != 0) && (wb0_addr == '0));
  assign wb1_ok = idle && wb1_en && !((ZERO_REG != 0) && (wb1_addr == '0));
  assign iss_ok = idle && iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  assign clr_busy   = !idle;
  assign debug_data = mem_q[debug_addr];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        // wb1 is applied after wb0 so the younger stage wins a same-address collision;
        // issue is applied last so a new producer keeps the register busy.
        if (wb0_ok) begin
          mem_d[wb0_addr]  = wb0_data;
          busy_d[wb0_addr] = 1'b0;
        end
        if (wb1_ok) begin
          mem_d[wb1_addr]  = wb1_data;
          busy_d[wb1_addr] = 1'b0;
        end
        if (iss_ok) begin
          busy_d[iss_addr] = 1'b1;
        end
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = CLR_START;
        end
      end
      CLEAR: begin
        mem_d[cnt_q]  = '0;
        busy_d[cnt_q] = 1'b0;
        if (cnt_q == CLR_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          is_zero;
    logic          hit0, hit1;

    assign a       = rd_addr[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (a == '0);
`ifdef RF_BYPASS_EN
    // The *_ok qualifiers already suppress forwarding during CLEAR and for x0.
    assign hit0 = wb0_ok && (wb0_addr == a);
    assign hit1 = wb1_ok && (wb1_addr == a);
`else
    assign hit0 = 1'b0;
    assign hit1 = 1'b0;
`endif
    assign rd_data[k*XLEN +: XLEN] = is_zero ? '0 :
                                     hit1    ? wb1_data :
                                     hit0    ? wb0_data : mem_q[a];
    // A register being written this cycle is no longer pending for the reader.
    assign rd_busy[k] = !is_zero && busy_q[a] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
module tb_regfile_bypass_sb;

  logic        clk = 1'b0;
  logic        rst;

  // Default build: XLEN=32, NREGS=32, NRD=2, ZERO_REG=1
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wb0_en, wb1_en, iss_en, clr_req, clr_busy;
  logic [4:0]  wb0_addr, wb1_addr, iss_addr, debug_addr;
  logic [31:0] wb0_data, wb1_data, debug_data;

  // Wide build: XLEN=64, NREGS=16, NRD=3, ZERO_REG=1
  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_wb0_en, b_wb1_en, b_iss_en, b_clr_req, b_clr_busy;
  logic [3:0]   b_wb0_addr, b_wb1_addr, b_iss_addr, b_debug_addr;
  logic [63:0]  b_wb0_data, b_wb1_data, b_debug_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_bypass_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .debug_addr(debug_addr), .debug_data(debug_data)
  );

  regfile_bypass_sb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wb0_en(b_wb0_en), .wb0_addr(b_wb0_addr), .wb0_data(b_wb0_data),
    .wb1_en(b_wb1_en), .wb1_addr(b_wb1_addr), .wb1_data(b_wb1_data),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy),
    .debug_addr(b_debug_addr), .debug_data(b_debug_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          n;
  logic [31:0] acc;
  logic        anyb;

  initial begin
    rst = 1'b1;
    rd_addr = '0; wb0_en = 0; wb1_en = 0; iss_en = 0; clr_req = 0;
    wb0_addr = '0; wb1_addr = '0; iss_addr = '0; debug_addr = '0;
    wb0_data = '0; wb1_data = '0;
    b_rd_addr = '0; b_wb0_en = 0; b_wb1_en = 0; b_iss_en = 0; b_clr_req = 0;
    b_wb0_addr = '0; b_wb1_addr = '0; b_iss_addr = '0; b_debug_addr = '0;
    b_wb0_data = '0; b_wb1_data = '0;

    // Reset state
    #3;
    chk("rst_clr_busy", {63'd0, clr_busy}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_rd_busy", {62'd0, rd_busy}, 64'd0);
    chk("rst_debug", {32'd0, debug_data}, 64'd0);
    #9 rst = 1'b0;   // t=12, away from posedges at 5/15

    // 1. wb0 x5 = DEADBEEF
    tick();
    wb0_en = 1; wb0_addr = 5; wb0_data = 32'hDEADBEEF; rd_addr[4:0] = 5;
    #1;
`ifdef RF_BYPASS_EN
    chk("x5_fwd", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
`else
    chk("x5_same_cycle", {32'd0, rd_data[31:0]}, 64'h0);
`endif
    tick();
    wb0_en = 0; debug_addr = 5;
    #1;
    chk("x5_read", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    chk("x5_debug", {32'd0, debug_data}, 64'hDEADBEEF);

    // x0 write dropped, including on the bypass path
    wb0_en = 1; wb0_addr = 0; wb0_data = 32'h1234; rd_addr[9:5] = 0;
    #1;
    chk("x0_same_cycle", {32'd0, rd_data[63:32]}, 64'h0);
    tick();
    wb0_en = 0; debug_addr = 0;
    #1;
    chk("x0_read", {32'd0, rd_data[63:32]}, 64'h0);
    chk("x0_debug", {32'd0, debug_data}, 64'h0);

    // 2. Same-address dual write: wb1 wins
    wb0_en = 1; wb0_addr = 7; wb0_data = 32'h11;
    wb1_en = 1; wb1_addr = 7; wb1_data = 32'h22; rd_addr[4:0] = 7;
    #1;
`ifdef RF_BYPASS_EN
    chk("x7_fwd_wb1", {32'd0, rd_data[31:0]}, 64'h22);
`else
    chk("x7_same_cycle", {32'd0, rd_data[31:0]}, 64'h0);
`endif
    tick();
    wb0_en = 0; wb1_en = 0;
    #1;
    chk("x7_wb1_wins", {32'd0, rd_data[31:0]}, 64'h22);

    // 3. Scoreboard on x9
    iss_en = 1; iss_addr = 9; rd_addr[9:5] = 9;
    tick();
    iss_en = 0;
    #1;
    chk("x9_busy_set", {63'd0, rd_busy[1]}, 64'd1);
    wb0_en = 1; wb0_addr = 9; wb0_data = 32'h99;
    #1;
`ifdef RF_BYPASS_EN
    chk("x9_busy_masked", {63'd0, rd_busy[1]}, 64'd0);
    chk("x9_fwd", {32'd0, rd_data[63:32]}, 64'h99);
`else
    chk("x9_busy_raw", {63'd0, rd_busy[1]}, 64'd1);
    chk("x9_same_cycle", {32'd0, rd_data[63:32]}, 64'h0);
`endif
    tick();
    wb0_en = 0;
    #1;
    chk("x9_busy_clr", {63'd0, rd_busy[1]}, 64'd0);
    chk("x9_data", {32'd0, rd_data[63:32]}, 64'h99);
    iss_en = 1; iss_addr = 9; wb1_en = 1; wb1_addr = 9; wb1_data = 32'hAA;
    tick();
    iss_en = 0; wb1_en = 0;
    #1;
    chk("x9_iss_wins", {63'd0, rd_busy[1]}, 64'd1);
    chk("x9_data_aa", {32'd0, rd_data[63:32]}, 64'hAA);

    // 4. Fill x1..x31, then sequenced clear
    for (int i = 1; i < 32; i++) begin
      wb0_en = 1; wb0_addr = 5'(i); wb0_data = 32'hA500_0000 + 32'(i);
      tick();
    end
    wb0_en = 0;
    iss_en = 1; iss_addr = 3;
    tick();
    iss_en = 0; rd_addr[4:0] = 31; rd_addr[9:5] = 3;
    #1;
    chk("fill_x31", {32'd0, rd_data[31:0]}, 64'hA500001F);
    chk("x3_busy", {63'd0, rd_busy[1]}, 64'd1);
    clr_req = 1;
    tick();
    clr_req = 0;
    n = 0;
    while (clr_busy && n < 100) begin
      wb1_en = 0; iss_en = 0;
      if (n == 0) begin
        wb1_en = 1; wb1_addr = 31; wb1_data = 32'h5555;
        #1;
        chk("clr_no_fwd", {32'd0, rd_data[31:0]}, 64'hA500001F);
      end
      if (n == 10) begin
        wb1_en = 1; wb1_addr = 1; wb1_data = 32'h5555;
        iss_en = 1; iss_addr = 2;
      end
      tick();
      n++;
    end
    wb1_en = 0; iss_en = 0;
    chk("clr_cycles", 64'(n), 64'd31);
    acc = '0; anyb = 1'b0;
    for (int i = 0; i < 32; i++) begin
      debug_addr = 5'(i); rd_addr[4:0] = 5'(i);
      #1;
      acc  = acc | debug_data;
      anyb = anyb | rd_busy[0];
    end
    chk("clr_all_zero", {32'd0, acc}, 64'd0);
    chk("clr_no_busy", {63'd0, anyb}, 64'd0);

    // 5. Reset in the middle of a clear
    wb0_en = 1; wb0_addr = 20; wb0_data = 32'h2020;
    tick();
    wb0_en = 0; clr_req = 1;
    tick();
    clr_req = 0;
    repeat (10) tick();
    chk("mid_clr_active", {63'd0, clr_busy}, 64'd1);
    rst = 1'b1; debug_addr = 20;
    #1;
    chk("rst_mid_clr_busy", {63'd0, clr_busy}, 64'd0);
    chk("rst_mid_clr_x20", {32'd0, debug_data}, 64'd0);
    #1 rst = 1'b0;
    tick();
    wb0_en = 1; wb0_addr = 20; wb0_data = 32'h77;
    tick();
    wb0_en = 0;
    #1;
    chk("post_rst_write", {32'd0, debug_data}, 64'h77);

    // 6. Wide build: three simultaneous 64-bit reads
    b_wb0_en = 1; b_wb0_addr = 3;  b_wb0_data = 64'h0123_4567_89AB_CDEF;
    b_wb1_en = 1; b_wb1_addr = 10; b_wb1_data = 64'hFEDC_BA98_7654_3210;
    tick();
    b_wb1_en = 0; b_wb0_addr = 15; b_wb0_data = 64'hCAFE_F00D_1234_5678;
    tick();
    b_wb0_en = 0;
    b_rd_addr = {4'd15, 4'd10, 4'd3};
    #1;
    chk("wide_p0", b_rd_data[63:0],    64'h0123_4567_89AB_CDEF);
    chk("wide_p1", b_rd_data[127:64],  64'hFEDC_BA98_7654_3210);
    chk("wide_p2", b_rd_data[191:128], 64'hCAFE_F00D_1234_5678);
    chk("wide_busy", {61'd0, b_rd_busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
